// File: rtl/uart_rx_frame.sv
// UART receiver (8N1, LSB first) that gathers five bytes into one 40-bit frame.
// Bytes are sampled mid-bit. A completed frame is published on rx_data with a
// one-cycle rx_valid pulse. A bad stop bit, or a partial frame left idle too
// long, discards the partial frame and pulses frame_err.
`timescale 1ns/1ps
module uart_rx_frame #(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 9600,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [39:0] rx_data,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        busy
);
   localparam int BIT_CNT     = CLK_FREQ / BAUD;
   localparam int TIMEOUT_CYC = TIMEOUT_BITS * BIT_CNT;
   localparam int CNT_W       = $clog2(BIT_CNT + 1);
   localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CNT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [1:0]       sync_reg;
   logic             rx_prev_reg;
   logic             rx_s;
   logic             rx_fall;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic [2:0]       byte_idx_reg, byte_idx_next;
   // Only slots 0..3 need storage: slot 4 goes straight into rx_data.
   logic [31:0]      staging_reg, staging_next;
   logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
   logic [39:0]      rx_data_reg, rx_data_next;
   logic             rx_valid_reg, rx_valid_next;
   logic             frame_err_reg, frame_err_next;

   assign rx_s    = sync_reg[1];
   assign rx_fall = rx_prev_reg & ~rx_s;

   // Two-flop synchroniser plus previous-value flop for falling-edge detection; idle-high preset.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[0], uart_rx};
         rx_prev_reg <= rx_s;
      end
   end

   // State and datapath registers.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         byte_idx_reg  <= '0;
         staging_reg   <= '0;
         to_cnt_reg    <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bit_idx_reg   <= bit_idx_next;
         shift_reg     <= shift_next;
         byte_idx_reg  <= byte_idx_next;
         staging_reg   <= staging_next;
         to_cnt_reg    <= to_cnt_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         frame_err_reg <= frame_err_next;
      end
   end

   // Next-state logic: bit timing, byte assembly, frame collection and timeout.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bit_idx_next   = bit_idx_reg;
      shift_next     = shift_reg;
      byte_idx_next  = byte_idx_reg;
      staging_next   = staging_reg;
      to_cnt_next    = to_cnt_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = 1'b0;
      frame_err_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (rx_fall) begin
               state_next  = START;
               cnt_next    = '0;
               to_cnt_next = '0;
            end else if (byte_idx_reg != 3'd0) begin
               // A partial frame left idle for too long is dropped.
               if (to_cnt_reg == TO_LAST) begin
                  to_cnt_next    = '0;
                  byte_idx_next  = '0;
                  staging_next   = '0;
                  frame_err_next = 1'b1;
               end else begin
                  to_cnt_next = to_cnt_reg + TO_ONE;
               end
            end
         end
         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next = '0;
               if (!rx_s) begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = IDLE;   // short glitch, not a start bit
               end
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next     = '0;
               shift_next   = {rx_s, shift_reg[7:1]};
               bit_idx_next = bit_idx_reg + 3'd1;
               if (bit_idx_reg == 3'd7) state_next = STOP;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
               if (rx_s) begin
                  if (byte_idx_reg == 3'd4) begin
                     rx_data_next  = {shift_reg, staging_reg};
                     rx_valid_next = 1'b1;
                     byte_idx_next = '0;
                  end else begin
                     staging_next[{byte_idx_reg[1:0], 3'b000} +: 8] = shift_reg;
                     byte_idx_next = byte_idx_reg + 3'd1;
                  end
               end else begin
                  frame_err_next = 1'b1;
                  byte_idx_next  = '0;
                  staging_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign frame_err = frame_err_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame. The bench models the receiver as a list of
// bytes: five good bytes form a frame. A bad stop bit, or a long idle gap
// while a frame is partly filled, clears that list and counts as one error.
`timescale 1ns/1ps
module tb_uart_rx_frame;
   localparam int CLK_FREQ     = 1_000_000;
   localparam int BAUD         = 100_000;
   localparam int TIMEOUT_BITS = 20;
   localparam int BIT_CNT      = CLK_FREQ / BAUD;

   logic        sys_clk = 1'b0;
   logic        rst     = 1'b1;
   logic        uart_rx = 1'b1;
   logic [39:0] rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // Observed events
   logic [39:0] got_frames[$];
   int          valid_cyc[$];
   int          got_errs = 0;
   int          overlaps = 0;

   // Reference model
   logic [7:0]  model_q[$];
   logic [39:0] exp_frames[$];
   int          exp_errs = 0;
   logic [39:0] exp_data = '0;

   uart_rx_frame #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BITS(TIMEOUT_BITS)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .uart_rx(uart_rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cycle <= cycle + 1;

   // Record output events on the falling edge, away from the active edge.
   always @(negedge sys_clk) begin
      if (!rst) begin
         if (rx_valid) begin
            got_frames.push_back(rx_data);
            valid_cyc.push_back(cycle);
         end
         if (frame_err) got_errs <= got_errs + 1;
         if (rx_valid && frame_err) overlaps <= overlaps + 1;
      end
   end

   task automatic line_bits(input logic v, input int nbits);
      uart_rx = v;
      repeat (nbits * BIT_CNT) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      line_bits(1'b0, 1);
      for (int i = 0; i < 8; i++) line_bits(b[i], 1);
      line_bits(stop_ok, 1);
      if (!stop_ok) begin
         line_bits(1'b1, 2);
         exp_errs++;
         model_q.delete();
      end else begin
         model_q.push_back(b);
         if (model_q.size() == 5) begin
            exp_data = {model_q[4], model_q[3], model_q[2], model_q[1], model_q[0]};
            exp_frames.push_back(exp_data);
            model_q.delete();
         end
      end
   endtask

   task automatic idle_gap(input int nbits);
      line_bits(1'b1, nbits);
      if (nbits >= TIMEOUT_BITS + 2 && model_q.size() != 0) begin
         exp_errs++;
         model_q.delete();
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++; if (rx_data !== 40'h0) begin failures++; $display("FAIL reset_rx_data: got=%h exp=0", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got=%b exp=0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got=%b exp=0", frame_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%b exp=0", busy); end
      rst = 1'b0;
      idle_gap(2);
      $display("test_reset done");
   endtask

   task automatic test_basic;
      int bf = got_frames.size();
      int be = got_errs;
      logic [7:0] bytes[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
      for (int i = 0; i < 5; i++) send_byte(bytes[i], 1'b1);
      idle_gap(2);
      checks++; if (got_frames.size() - bf !== 1) begin failures++; $display("FAIL basic_valid_count: got=%0d exp=1", got_frames.size() - bf); end
      checks++; if (rx_data !== 40'h10_08_04_02_01) begin failures++; $display("FAIL basic_rx_data: got=%h exp=1008040201", rx_data); end
      checks++; if (rx_data !== exp_data) begin failures++; $display("FAIL basic_model: got=%h exp=%h", rx_data, exp_data); end
      checks++; if (got_errs - be !== 0) begin failures++; $display("FAIL basic_no_err: got=%0d exp=0", got_errs - be); end
      $display("test_basic rx_data=%h", rx_data);
   endtask

   task automatic test_glitch;
      int bf = got_frames.size();
      int be = got_errs;
      logic saw_busy = 1'b0;
      @(posedge sys_clk); #1;
      uart_rx = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1 uart_rx = 1'b1;
      repeat (20) begin
         @(negedge sys_clk);
         if (busy) saw_busy = 1'b1;
      end
      checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen: got=%b exp=1", saw_busy); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop: got=%b exp=0", busy); end
      checks++; if (got_frames.size() - bf !== 0) begin failures++; $display("FAIL glitch_no_valid: got=%0d exp=0", got_frames.size() - bf); end
      checks++; if (got_errs - be !== 0) begin failures++; $display("FAIL glitch_no_err: got=%0d exp=0", got_errs - be); end
      idle_gap(1);
      $display("test_glitch busy_seen=%b", saw_busy);
   endtask

   task automatic test_stop_err;
      int bf = got_frames.size();
      int be = got_errs;
      logic [39:0] prev = exp_data;
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b0);
      checks++; if (got_errs - be !== 1) begin failures++; $display("FAIL stoperr_pulse: got=%0d exp=1", got_errs - be); end
      checks++; if (rx_data !== prev) begin failures++; $display("FAIL stoperr_hold: got=%h exp=%h", rx_data, prev); end
      for (int i = 1; i <= 5; i++) send_byte(8'(8'hA0 + i), 1'b1);
      idle_gap(2);
      checks++; if (rx_data !== 40'hA5_A4_A3_A2_A1) begin failures++; $display("FAIL stoperr_recover: got=%h exp=A5A4A3A2A1", rx_data); end
      checks++; if (got_frames.size() - bf !== 1) begin failures++; $display("FAIL stoperr_valid_count: got=%0d exp=1", got_frames.size() - bf); end
      checks++; if (got_errs - be !== 1) begin failures++; $display("FAIL stoperr_err_total: got=%0d exp=1", got_errs - be); end
      $display("test_stop_err rx_data=%h", rx_data);
   endtask

   task automatic test_timeout;
      int bf = got_frames.size();
      int be = got_errs;
      logic [39:0] prev = exp_data;
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b1);
      idle_gap(25);
      checks++; if (got_errs - be !== 1) begin failures++; $display("FAIL timeout_pulse: got=%0d exp=1", got_errs - be); end
      checks++; if (got_frames.size() - bf !== 0) begin failures++; $display("FAIL timeout_no_valid: got=%0d exp=0", got_frames.size() - bf); end
      checks++; if (rx_data !== prev) begin failures++; $display("FAIL timeout_hold: got=%h exp=%h", rx_data, prev); end
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
      idle_gap(25);
      checks++; if (rx_data !== exp_data) begin failures++; $display("FAIL timeout_recover: got=%h exp=%h", rx_data, exp_data); end
      checks++; if (got_errs - be !== 1) begin failures++; $display("FAIL timeout_idle_no_err: got=%0d exp=1", got_errs - be); end
      $display("test_timeout rx_data=%h", rx_data);
   endtask

   task automatic test_reset_mid;
      int bf;
      int be;
      logic [7:0] b = 8'($urandom);
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b1);
      line_bits(1'b0, 1);
      for (int i = 0; i < 4; i++) line_bits(b[i], 1);
      uart_rx = b[4];
      repeat (5) @(posedge sys_clk);
      #1 rst = 1'b1;
      @(negedge sys_clk);
      checks++; if (rx_data !== 40'h0) begin failures++; $display("FAIL rstmid_rx_data: got=%h exp=0", rx_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got=%b exp=0", busy); end
      checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_pulses: got=%b%b exp=00", rx_valid, frame_err); end
      uart_rx = 1'b1;
      @(posedge sys_clk);
      #1 rst = 1'b0;
      model_q.delete();
      exp_data = '0;
      bf = got_frames.size();
      be = got_errs;
      idle_gap(3);
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h3C, 1'b1);
      idle_gap(2);
      checks++; if (rx_data !== 40'h3C_FF_00_AA_55) begin failures++; $display("FAIL rstmid_frame: got=%h exp=3CFF00AA55", rx_data); end
      checks++; if (got_frames.size() - bf !== 1) begin failures++; $display("FAIL rstmid_valid_count: got=%0d exp=1", got_frames.size() - bf); end
      checks++; if (got_errs - be !== 0) begin failures++; $display("FAIL rstmid_no_err: got=%0d exp=0", got_errs - be); end
      $display("test_reset_mid rx_data=%h", rx_data);
   endtask

   task automatic test_back_to_back;
      int bf = got_frames.size();
      int xf = exp_frames.size();
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1);
      idle_gap(2);
      checks++;
      if (got_frames.size() - bf !== 2) begin
         failures++; $display("FAIL b2b_valid_count: got=%0d exp=2", got_frames.size() - bf);
      end else begin
         checks++; if (valid_cyc[bf+1] - valid_cyc[bf] !== 50 * BIT_CNT) begin failures++; $display("FAIL b2b_spacing: got=%0d exp=%0d", valid_cyc[bf+1] - valid_cyc[bf], 50 * BIT_CNT); end
         checks++; if (got_frames[bf] !== exp_frames[xf]) begin failures++; $display("FAIL b2b_frame0: got=%h exp=%h", got_frames[bf], exp_frames[xf]); end
         checks++; if (got_frames[bf+1] !== exp_frames[xf+1]) begin failures++; $display("FAIL b2b_frame1: got=%h exp=%h", got_frames[bf+1], exp_frames[xf+1]); end
      end
      checks++; if (rx_data !== exp_data) begin failures++; $display("FAIL b2b_rx_data: got=%h exp=%h", rx_data, exp_data); end
      $display("test_back_to_back rx_data=%h", rx_data);
   endtask

   task automatic test_random;
      int bf = got_frames.size();
      int be = got_errs;
      int xf = exp_frames.size();
      int xe = exp_errs;
      int nf;
      for (int i = 0; i < 40; i++) begin
         int r = int'($urandom_range(0, 19));
         send_byte(8'($urandom), ($urandom_range(0, 9) != 0));
         if (r >= 19)      idle_gap(25);
         else if (r >= 14) idle_gap(int'($urandom_range(1, 5)));
      end
      idle_gap(25);
      nf = exp_frames.size() - xf;
      checks++;
      if (got_frames.size() - bf !== nf) begin
         failures++; $display("FAIL rand_valid_count: got=%0d exp=%0d", got_frames.size() - bf, nf);
      end else begin
         for (int i = 0; i < nf; i++) begin
            checks++; if (got_frames[bf+i] !== exp_frames[xf+i]) begin failures++; $display("FAIL rand_frame%0d: got=%h exp=%h", i, got_frames[bf+i], exp_frames[xf+i]); end
         end
      end
      checks++; if (got_errs - be !== exp_errs - xe) begin failures++; $display("FAIL rand_err_count: got=%0d exp=%0d", got_errs - be, exp_errs - xe); end
      checks++; if (rx_data !== exp_data) begin failures++; $display("FAIL rand_rx_data: got=%h exp=%h", rx_data, exp_data); end
      $display("test_random frames=%0d errs=%0d", nf, exp_errs - xe);
   endtask

   task automatic test_exclusive;
      checks++; if (overlaps !== 0) begin failures++; $display("FAIL exclusive_pulses: got=%0d exp=0", overlaps); end
      $display("test_exclusive overlaps=%0d", overlaps);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_stop_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, is the sys_clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, is the serial bit rate; BIT_CNT = CLK_FREQ/BAUD (integer divide).
REQ-003 Parameter TIMEOUT_BITS, default 20, is the idle gap in bit periods after which a partial frame is discarded.
REQ-004 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 uart_rx  input  1  serial line, idle high, 8N1, LSB first, asynchronous to sys_clk.
REQ-007 rx_data  output  40  last complete 5-byte frame; first received byte in [7:0], fifth in [39:32].
REQ-008 rx_valid  output  1  one-cycle pulse; rx_data newly updated.
REQ-009 frame_err  output  1  one-cycle pulse on stop-bit error or timeout discard.
REQ-010 busy  output  1  high while a byte is being received (any state except IDLE).

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchroniser, preset to 1 on reset; all decisions use the synchronised value.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on a synchronised 1->0 transition; bit counter cleared.
REQ-014 START: at count BIT_CNT/2-1, line low -> DATA with counter cleared; line high -> IDLE (glitch rejected, no error, byte index unchanged).
REQ-015 DATA: sample one bit each time the counter reaches BIT_CNT-1 (mid-bit), shift into bit 7 of shift register (LSB first); after 8 samples -> STOP.
REQ-016 STOP: sample at BIT_CNT-1; high -> byte accepted, low -> framing error; either case -> IDLE.
REQ-017 Accepted byte SHALL be written into staging register slot byte_idx (0..4), byte_idx then incremented.
REQ-018 When the byte written is slot 4: rx_data <= staging contents including that byte on the next edge, rx_valid pulses that same cycle, byte_idx wraps to 0.
REQ-019 Latency: rx_valid SHALL assert exactly 1 cycle after the stop-bit sample of the fifth byte.
REQ-020 Framing error SHALL pulse frame_err, clear byte_idx to 0, discard staging, leave rx_data unchanged.
REQ-021 Timeout counter runs in IDLE when byte_idx != 0; reaching TIMEOUT_BITS*BIT_CNT cycles -> byte_idx cleared, frame_err pulses once; counter cleared on any start edge.
REQ-022 rx_valid and frame_err SHALL never be high in the same cycle; each is high for at most one cycle per event.
REQ-023 rx_data SHALL hold its value between frames; a new frame overwrites it fully.
REQ-024 A falling edge arriving in the same cycle STOP completes SHALL be ignored; detection resumes from IDLE on the next cycle.

Reset
REQ-025 While rst high: state IDLE, counters 0, byte_idx 0, staging 0, rx_data 40'h0, rx_valid 0, frame_err 0, busy 0, synchroniser 1.
REQ-026 Reset asserted mid-byte or mid-frame SHALL discard all partial data; after release the first falling edge starts byte 0.

Verification
REQ-027 CLK_FREQ=1_000_000, BAUD=100_000 (BIT_CNT=10): send 01,02,04,08,10 back-to-back -> one rx_valid, rx_data=40'h10_08_04_02_01, frame_err never high.
REQ-028 2-cycle low glitch on uart_rx in IDLE -> returns to IDLE, busy drops, no rx_valid, no frame_err.
REQ-029 Third byte sent with stop bit 0 -> frame_err one pulse, rx_data unchanged, next 5 good bytes A1..A5 -> rx_data=40'hA5_A4_A3_A2_A1.
REQ-030 Send 2 bytes then idle 200+ cycles (TIMEOUT_BITS=20) -> frame_err one pulse; next 5 bytes produce a correct frame.
REQ-031 Assert rst during byte 3 bit 4 -> all outputs at reset values; after release 5 bytes 55,AA,00,FF,3C -> rx_data=40'h3C_FF_00_AA_55.
REQ-032 Two frames with zero gap -> two rx_valid pulses, 50 bit periods apart, second value replaces first.
